// File: rtl/tp_ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one two-port RAM between NUM_PORTS requesters.
// Optional write-to-read forwarding on same-cycle address collision: define TP_RAM_ARB_RAW_FWD_EN.
module tp_ram_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 1,
  parameter int IDX_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                                 Clk_CI,
  input  logic                                 Rst_RBI,
  input  logic [NUM_PORTS-1:0]                 WrValid_SI,
  output logic [NUM_PORTS-1:0]                 WrReady_SO,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] WrAddr_DI,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] WrData_DI,
  input  logic [NUM_PORTS-1:0]                 RdValid_SI,
  output logic [NUM_PORTS-1:0]                 RdReady_SO,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] RdAddr_DI,
  output logic [NUM_PORTS-1:0]                 RspValid_SO,
  output logic [DATA_WIDTH-1:0]                RspData_DO,
  output logic                                 RamWrEn_SO,
  output logic [ADDR_WIDTH-1:0]                RamWrAddr_DO,
  output logic [DATA_WIDTH-1:0]                RamWrData_DO,
  output logic                                 RamRdEn_SO,
  output logic [ADDR_WIDTH-1:0]                RamRdAddr_DO,
  input  logic [DATA_WIDTH-1:0]                RamRdData_DI
);

  if (RAM_LATENCY != 1 && RAM_LATENCY != 2) begin : g_bad_latency
    $error("tp_ram_arbiter: RAM_LATENCY must be 1 or 2");
  end
  if (NUM_PORTS < 2) begin : g_bad_ports
    $error("tp_ram_arbiter: NUM_PORTS must be at least 2");
  end

  logic [IDX_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 wr_gnt, rd_gnt;
  logic [IDX_WIDTH-1:0] wr_idx, rd_idx;

  logic [RAM_LATENCY-1:0]                tag_vld_q;
  logic [RAM_LATENCY-1:0][IDX_WIDTH-1:0] tag_idx_q;

  // Scan from the pointer upwards with wrap; iterating backwards lets the closest requester win.
  function automatic logic [IDX_WIDTH:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                 input logic [IDX_WIDTH-1:0] ptr);
    logic [IDX_WIDTH:0]   res;
    logic [IDX_WIDTH-1:0] idx;
    int                   j;
    res = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      idx = IDX_WIDTH'(j);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] idx);
    return (idx == IDX_WIDTH'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    {wr_gnt, wr_idx} = rr_pick(WrValid_SI, wr_ptr_q);
    {rd_gnt, rd_idx} = rr_pick(RdValid_SI, rd_ptr_q);
    wr_ptr_d = wr_gnt ? next_idx(wr_idx) : wr_ptr_q;
    rd_ptr_d = rd_gnt ? next_idx(rd_idx) : rd_ptr_q;
  end

  always_comb begin
    WrReady_SO = '0;
    RdReady_SO = '0;
    if (wr_gnt) WrReady_SO[wr_idx] = 1'b1;
    if (rd_gnt) RdReady_SO[rd_idx] = 1'b1;
  end

  assign RamWrEn_SO   = wr_gnt;
  assign RamWrAddr_DO = wr_gnt ? WrAddr_DI[wr_idx] : '0;
  assign RamWrData_DO = wr_gnt ? WrData_DI[wr_idx] : '0;
  assign RamRdEn_SO   = rd_gnt;
  assign RamRdAddr_DO = rd_gnt ? RdAddr_DI[rd_idx] : '0;

`ifdef TP_RAM_ARB_RAW_FWD_EN
  logic [RAM_LATENCY-1:0]                 fwd_hit_q;
  logic [RAM_LATENCY-1:0][DATA_WIDTH-1:0] fwd_data_q;
  logic                                   fwd_hit_d;

  assign fwd_hit_d = wr_gnt && rd_gnt && (RamWrAddr_DO == RamRdAddr_DO);
`endif

  // Tag pipeline shifts towards the top index; stage 0 takes this cycle's read grant.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_vld_q <= '0;
      tag_idx_q <= '0;
`ifdef TP_RAM_ARB_RAW_FWD_EN
      fwd_hit_q  <= '0;
      fwd_data_q <= '0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tag_vld_q <= RAM_LATENCY'({tag_vld_q, rd_gnt});
      tag_idx_q <= (RAM_LATENCY*IDX_WIDTH)'({tag_idx_q, rd_idx});
`ifdef TP_RAM_ARB_RAW_FWD_EN
      fwd_hit_q  <= RAM_LATENCY'({fwd_hit_q, fwd_hit_d});
      fwd_data_q <= (RAM_LATENCY*DATA_WIDTH)'({fwd_data_q, RamWrData_DO});
`endif
    end
  end

  always_comb begin
    RspValid_SO = '0;
    if (tag_vld_q[RAM_LATENCY-1]) RspValid_SO[tag_idx_q[RAM_LATENCY-1]] = 1'b1;
  end

`ifdef TP_RAM_ARB_RAW_FWD_EN
  assign RspData_DO = fwd_hit_q[RAM_LATENCY-1] ? fwd_data_q[RAM_LATENCY-1] : RamRdData_DI;
`else
  assign RspData_DO = RamRdData_DI;
`endif

endmodule
